// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter that shares the async FIFO write port (UART
//            TX path) between NUM_REQ byte producers. One requester owns the
//            port for a burst that ends on end-of-packet or after MAX_BURST
//            words. Writes are held off while the FIFO reports full.
//            Lives in the FIFO write clock domain.
//
// Ports    : clk_i           write-domain clock
//            rst_i           synchronous reset, active-high
//            req_valid_i     per-requester word valid
//            req_data_i      packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//            req_last_i      per-requester end-of-packet marker
//            req_ready_o     per-requester accept (only the owner, only when not full)
//            fifo_full_i     FIFO full flag
//            fifo_wr_en_o    FIFO write strobe
//            fifo_wr_data_o  FIFO write data (owner slice while owning, else 0)
//            grant_o         one-hot current owner, 0 when idle
//            busy_o          high while a requester owns the port
//
// Options  : FIFO_WR_ARB_TIMEOUT_EN - when defined, an owner that presents no
//            valid word for TIMEOUT_CYCLES consecutive cycles loses the grant.
//
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = 8;

    localparam logic [c_IDX_W-1:0] c_PTR_RST    = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);

    // Elaboration-time range checks on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_max_burst
        $error("fifo_wr_arbiter: MAX_BURST must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("fifo_wr_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_ptr;     // last winner; equals the owner while in S_OWN
    logic [c_CNT_W-1:0]   r_count;   // words written in the current burst
    logic                 r_busy;

    logic                 w_any_valid;
    logic [c_IDX_W-1:0]   w_winner;
    logic [NUM_REQ-1:0]   w_winner_onehot;
    logic                 w_own;
    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic                 w_write;
    logic                 w_release;
    logic                 w_timeout;

    // ------------------------------------------------------------------------
    // Round-robin search. Offsets are scanned from the furthest (the pointer
    // itself) down to the nearest (pointer+1) so the closest valid requester
    // after the pointer overwrites any earlier candidate.
    // ------------------------------------------------------------------------
    always_comb begin
        w_any_valid = |req_valid_i;
        w_winner    = r_ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_winner = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
        w_winner_onehot = NUM_REQ'(1) << w_winner;
    end

    // ------------------------------------------------------------------------
    // Owner datapath. Ready/write are combinational so a word is accepted in
    // the same cycle the FIFO has room.
    // ------------------------------------------------------------------------
    assign w_own          = (r_state == S_OWN);
    assign w_owner_valid  = req_valid_i[r_ptr];
    assign w_owner_last   = req_last_i[r_ptr];
    assign w_write        = w_own & ~fifo_full_i & w_owner_valid;
    // Burst ends on the word that carries last or that fills MAX_BURST.
    assign w_release      = w_write & (w_owner_last | (r_count == c_BURST_LAST));

    assign req_ready_o    = (w_own & ~fifo_full_i) ? r_grant : '0;
    assign fifo_wr_en_o   = w_write;
    assign fifo_wr_data_o = w_own ? req_data_i[int'(r_ptr)*DATA_WIDTH +: DATA_WIDTH]
                                  : '0;
    assign grant_o        = r_grant;
    assign busy_o         = r_busy;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_idle_cnt;

    // Counts consecutive owning cycles with no valid word from the owner.
    // A stalled-but-valid owner clears it, so FIFO backpressure never revokes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle_cnt <= '0;
        end else if (!w_own || w_owner_valid || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Revoke on the cycle that would make the idle count reach the threshold.
    assign w_timeout = w_own & ~w_owner_valid & (r_idle_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Ownership state machine.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= c_PTR_RST;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_state <= S_OWN;
                        r_grant <= w_winner_onehot;
                        r_ptr   <= w_winner;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_OWN: begin
                    // The pointer keeps the owner index, so the next search
                    // starts just after it.
                    if (w_release || w_timeout) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_write) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter (default
//            parameters: 4 requesters, 8-bit data, MAX_BURST=4,
//            TIMEOUT_CYCLES=16). Expectations for the idle-owner timeout
//            follow FIFO_WR_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int c_N  = 4;
    localparam int c_DW = 8;

    logic               r_clk = 1'b0;
    logic               r_rst;
    logic [c_N-1:0]     r_req_valid;
    logic [c_N*c_DW-1:0] r_req_data;
    logic [c_N-1:0]     r_req_last;
    logic               r_fifo_full;
    logic [c_N-1:0]     w_req_ready;
    logic               w_fifo_wr_en;
    logic [c_DW-1:0]    w_fifo_wr_data;
    logic [c_N-1:0]     w_grant;
    logic               w_busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ        (4),
        .DATA_WIDTH     (8),
        .MAX_BURST      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i          (r_clk),
        .rst_i          (r_rst),
        .req_valid_i    (r_req_valid),
        .req_data_i     (r_req_data),
        .req_last_i     (r_req_last),
        .req_ready_o    (w_req_ready),
        .fifo_full_i    (r_fifo_full),
        .fifo_wr_en_o   (w_fifo_wr_en),
        .fifo_wr_data_o (w_fifo_wr_data),
        .grant_o        (w_grant),
        .busy_o         (w_busy)
    );

    always #5 r_clk = ~r_clk;

    // Advance one clock; inputs are changed and outputs sampled 2-3 ns after
    // the rising edge, well clear of it.
    task automatic tick();
        @(posedge r_clk);
        #2;
    endtask

    task automatic set_data(input int k, input logic [c_DW-1:0] v);
        r_req_data[k*c_DW +: c_DW] = v;
    endtask

    task automatic do_reset();
        r_rst       = 1'b1;
        r_req_valid = '0;
        r_req_last  = '0;
        r_req_data  = '0;
        r_fifo_full = 1'b0;
        tick();
        tick();
        r_rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        r_rst       = 1'b1;
        r_req_valid = 4'b1111;
        r_req_last  = '0;
        r_req_data  = 32'h44332211;
        r_fifo_full = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", w_grant); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", w_busy); end
        checks++; if (w_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", w_req_ready); end
        checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", w_fifo_wr_en); end
        checks++; if (w_fifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", w_fifo_wr_data); end
        r_rst = 1'b0;
        r_req_valid = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_packet();
        do_reset();
        r_req_valid = 4'b0001;
        set_data(0, 8'hA0);
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL sp_idle_grant: got %b expected 0000", w_grant); end
        checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL sp_idle_wr_en: got %b expected 0", w_fifo_wr_en); end
        tick();
        #1;
        checks++; if (w_grant !== 4'b0001) begin errors++; $display("FAIL sp_grant: got %b expected 0001", w_grant); end
        checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL sp_busy: got %b expected 1", w_busy); end
        for (int n = 0; n < 3; n++) begin
            set_data(0, 8'hA0 + 8'(n));
            r_req_last[0] = (n == 2);
            #1;
            checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL sp_wr_en[%0d]: got %b expected 1", n, w_fifo_wr_en); end
            checks++; if (w_fifo_wr_data !== 8'hA0 + 8'(n)) begin errors++; $display("FAIL sp_data[%0d]: got %h expected %h", n, w_fifo_wr_data, 8'hA0 + 8'(n)); end
            checks++; if (w_req_ready !== 4'b0001) begin errors++; $display("FAIL sp_ready[%0d]: got %b expected 0001", n, w_req_ready); end
            tick();
        end
        r_req_valid = '0;
        r_req_last  = '0;
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL sp_release_grant: got %b expected 0000", w_grant); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL sp_release_busy: got %b expected 0", w_busy); end
        checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL sp_release_wr_en: got %b expected 0", w_fifo_wr_en); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        do_reset();
        for (int k = 0; k < c_N; k++) set_data(k, 8'h30 + 8'(k));
        r_req_valid = 4'b1111;
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL rr_start_grant: got %b expected 0000", w_grant); end
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            exp_d = 8'h30 + 8'(order[g]);
            tick();
            for (int w = 0; w < 4; w++) begin
                #1;
                checks++; if (w_grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d.%0d]: got %b expected %b", g, w, w_grant, exp_g); end
                checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en[%0d.%0d]: got %b expected 1", g, w, w_fifo_wr_en); end
                checks++; if (w_fifo_wr_data !== exp_d) begin errors++; $display("FAIL rr_data[%0d.%0d]: got %h expected %h", g, w, w_fifo_wr_data, exp_d); end
                tick();
            end
            #1;
            checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL rr_gap_grant[%0d]: got %b expected 0000", g, w_grant); end
            checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rr_gap_wr_en[%0d]: got %b expected 0", g, w_fifo_wr_en); end
        end
        r_req_valid = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_full_stall();
        do_reset();
        set_data(2, 8'hC2);
        r_req_valid = 4'b0100;
        tick();
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL fs_pre_wr_en[%0d]: got %b expected 1", w, w_fifo_wr_en); end
            tick();
        end
        r_fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++; if (w_req_ready !== 4'b0000) begin errors++; $display("FAIL fs_ready[%0d]: got %b expected 0000", s, w_req_ready); end
            checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL fs_wr_en[%0d]: got %b expected 0", s, w_fifo_wr_en); end
            checks++; if (w_grant !== 4'b0100) begin errors++; $display("FAIL fs_grant[%0d]: got %b expected 0100", s, w_grant); end
            tick();
        end
        r_fifo_full = 1'b0;
        // Count was 2 before the stall, so exactly two more words fit the burst.
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL fs_post_wr_en[%0d]: got %b expected 1", w, w_fifo_wr_en); end
            checks++; if (w_req_ready !== 4'b0100) begin errors++; $display("FAIL fs_post_ready[%0d]: got %b expected 0100", w, w_req_ready); end
            checks++; if (w_grant !== 4'b0100) begin errors++; $display("FAIL fs_post_grant[%0d]: got %b expected 0100", w, w_grant); end
            tick();
        end
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL fs_release_grant: got %b expected 0000", w_grant); end
        r_req_valid = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        do_reset();
        set_data(1, 8'hB1);
        r_req_valid = 4'b0010;
        tick();
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL rm_wr_en[%0d]: got %b expected 1", w, w_fifo_wr_en); end
            tick();
        end
        r_rst       = 1'b1;
        r_req_valid = 4'b1111;
        tick();
        #1;
        checks++; if (w_grant !== 4'b0000) begin errors++; $display("FAIL rm_grant: got %b expected 0000", w_grant); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", w_busy); end
        checks++; if (w_req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b expected 0000", w_req_ready); end
        checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en: got %b expected 0", w_fifo_wr_en); end
        r_rst = 1'b0;
        tick();
        #1;
        checks++; if (w_grant !== 4'b0001) begin errors++; $display("FAIL rm_first_winner: got %b expected 0001", w_grant); end
        r_req_valid = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        logic [3:0] exp_after;
        logic [3:0] exp_next;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        exp_after = 4'b0000;
        exp_next  = 4'b1000;
`else
        exp_after = 4'b0010;
        exp_next  = 4'b0010;
`endif
        do_reset();
        set_data(1, 8'h71);
        set_data(3, 8'h73);
        r_req_valid = 4'b1010;
        tick();
        #1;
        checks++; if (w_grant !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b expected 0010", w_grant); end
        checks++; if (w_fifo_wr_en !== 1'b1) begin errors++; $display("FAIL to_first_wr_en: got %b expected 1", w_fifo_wr_en); end
        tick();
        r_req_valid = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (w_grant !== 4'b0010) begin errors++; $display("FAIL to_hold_grant[%0d]: got %b expected 0010", i, w_grant); end
            checks++; if (w_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL to_hold_wr_en[%0d]: got %b expected 0", i, w_fifo_wr_en); end
            tick();
        end
        #1;
        checks++; if (w_grant !== exp_after) begin errors++; $display("FAIL to_after_grant: got %b expected %b", w_grant, exp_after); end
        tick();
        #1;
        checks++; if (w_grant !== exp_next) begin errors++; $display("FAIL to_next_grant: got %b expected %b", w_grant, exp_next); end
        r_req_valid = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic prev_wr;
        logic exp_wr;
        do_reset();
        set_data(3, 8'h5A);
        r_req_valid = 4'b1000;
        r_req_last  = 4'b1000;
        prev_wr     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_wr = (i % 2 == 1);
            #1;
            checks++; if (w_fifo_wr_en !== exp_wr) begin errors++; $display("FAIL bb_wr_en[%0d]: got %b expected %b", i, w_fifo_wr_en, exp_wr); end
            checks++; if (w_grant !== (exp_wr ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL bb_grant[%0d]: got %b expected %b", i, w_grant, exp_wr ? 4'b1000 : 4'b0000); end
            checks++; if (prev_wr && w_fifo_wr_en) begin errors++; $display("FAIL bb_consecutive[%0d]: got two writes in a row, expected gap", i); end
            prev_wr = w_fifo_wr_en;
            tick();
        end
        r_req_valid = '0;
        r_req_last  = '0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        r_rst       = 1'b1;
        r_req_valid = '0;
        r_req_data  = '0;
        r_req_last  = '0;
        r_fifo_full = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_stall();
        test_reset_mid_burst();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the async FIFO write port (UART TX path) between NUM_REQ byte producers.
- Grants ownership to one requester for a burst, which ends on end-of-packet or MAX_BURST words.
- Honours the FIFO full flag.
- Sits in the write clock domain, directly in front of the async FIFO write side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, word width written to FIFO
MAX_BURST, 4, max words per grant before forced release (1..255)
TIMEOUT_CYCLES, 16, idle-owner revoke threshold (used only with the optional feature)

Ports:
clk_i  in  1  write-domain clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester word valid
req_data_i  in  NUM_REQ*DATA_WIDTH  packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
req_last_i  in  NUM_REQ  word is final of packet
req_ready_o  out  NUM_REQ  per-requester accept
fifo_full_i  in  1  FIFO full flag (write domain)
fifo_wr_en_o  out  1  FIFO write strobe
fifo_wr_data_o  out  DATA_WIDTH  FIFO write data
grant_o  out  NUM_REQ  one-hot current owner, 0 when none
busy_o  out  1  high while in OWN

Behaviour:
- Single clock, synchronous active-high reset. All state updates on rising clk_i.
- Reset values:
  - state=IDLE, grant_o=0, busy_o=0, burst count=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - req_ready_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0.
- State IDLE:
  - If any req_valid_i is set, pick the first set bit searching upward (mod NUM_REQ) from pointer+1.
  - Next cycle: state=OWN, grant_o=one-hot(winner), pointer=winner, count=0.
  - No writes occur in IDLE. Arbitration latency is 1 cycle.
- State OWN, owner k:
  - req_ready_o[k] = !fifo_full_i (combinational). All other ready bits are 0.
  - fifo_wr_en_o = req_valid_i[k] & req_ready_o[k] (combinational).
  - fifo_wr_data_o = slice k of req_data_i whenever in OWN, 0 otherwise.
  - Each write increments count.
  - Release when a write has req_last_i[k]=1, or when the write makes count==MAX_BURST. Next cycle: state=IDLE, grant_o=0.
- Fairness:
  - After release, the next search starts from k+1.
  - A continuously requesting requester cannot win twice while another requester is valid.
- fifo_full_i high: ready low, no write, count held, ownership held. Resumes the cycle full drops.
- Owner valid low mid-burst: ownership held; count unchanged.
- Non-owner valid: ignored; its ready stays 0 (requesters hold data until ready).
- MAX_BURST=1: every grant is exactly one word.
- Reset asserted mid-burst: return to reset values next edge. A partially written packet is not rolled back.
- Invariants:
  - At most one ready bit high; grant_o is one-hot or zero.
  - fifo_wr_en_o is never high while fifo_full_i=1.

Optional Feature:
- Macro FIFO_WR_ARB_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive OWN cycles with req_valid_i[k]=0, and clears on any owner-valid cycle.
  - When it reaches TIMEOUT_CYCLES, ownership is revoked: IDLE on the next cycle, pointer=k.
  - Cycles stalled by fifo_full_i while valid=1 do not count.
- Undefined: no counter logic; an owner holds the grant indefinitely until last or MAX_BURST.

Test Plan:
1. Reset, then req_valid_i=4'b0001, 3 words with last on the 3rd:
   - grant_o=0001 one cycle after valid.
   - 3 consecutive fifo_wr_en_o pulses with data A0,A1,A2.
   - grant_o=0 the cycle after the 3rd write.
2. All four valid continuously, no last, MAX_BURST=4:
   - Grants in order 0,1,2,3,0.
   - Each grant writes exactly 4 words.
   - One IDLE cycle between grants.
3. Owner 2 writing, fifo_full_i high for 5 cycles mid-burst:
   - req_ready_o=0 and fifo_wr_en_o=0 for those 5 cycles.
   - grant_o stays 0100, count unchanged.
   - Writes resume the cycle full drops.
4. rst_i asserted during a burst at count=2:
   - Next cycle: grant_o=0, busy_o=0, all ready 0.
   - After reset, requester 0 wins first.
5. With FIFO_WR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16:
   - Owner 1 drops valid after 1 word, while requester 3 is valid.
   - Grant revoked after 16 idle cycles; grant_o=1000 two cycles later.
   - Without the macro, grant stays 0010.
6. Single requester 3 valid, with last on every word:
   - Alternating IDLE/OWN cycles.
   - One write every 2 cycles, never two writes in consecutive cycles.
